// File: rtl/led_color_seq_pkg.sv
// Shared types and constants for the LED colour sequencer.
// Gamma correction is enabled by defining LED_COLOR_SEQ_GAMMA_EN.
package led_color_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    STEP = 2'b01,
    FADE = 2'b10
  } mode_e;

  localparam logic [2:0] SEG_RED     = 3'd0;
  localparam logic [2:0] SEG_YELLOW  = 3'd1;
  localparam logic [2:0] SEG_GREEN   = 3'd2;
  localparam logic [2:0] SEG_CYAN    = 3'd3;
  localparam logic [2:0] SEG_BLUE    = 3'd4;
  localparam logic [2:0] SEG_MAGENTA = 3'd5;
  localparam int         NUM_SEGS    = 6;

endpackage

// File: rtl/led_color_seq_pwm_ch.sv
// One PWM channel: optional gamma, brightness scaling and a registered compare.
// Gamma squaring is built only when LED_COLOR_SEQ_GAMMA_EN is defined.
module led_pwm_ch
  import led_color_seq_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] level,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                out
);

  localparam int PW = 2 * PWM_BITS + 1;

  logic [PWM_BITS-1:0] lvl;
  logic [PW-1:0]       prod;
  logic [PW-1:0]       duty;

`ifdef LED_COLOR_SEQ_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq  = level * level;
  assign lvl = PWM_BITS'(sq >> PWM_BITS);
`else
  assign lvl = level;
`endif

  // brightness+1 keeps full brightness an exact pass-through of the level
  assign prod = PW'(lvl) * (PW'(brightness) + PW'(1));
  assign duty = prod >> PWM_BITS;

  always_ff @(posedge clk) begin
    if (!rst_n) out <= 1'b0;
    else        out <= (duty > PW'(pwm_cnt));
  end

endmodule

// File: rtl/led_color_seq.sv
// Hue-wheel colour sequencer driving three PWM LED channels (step or fade).
// Define LED_COLOR_SEQ_GAMMA_EN to square levels before brightness scaling.
module led_color_seq
  import led_color_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 6000000,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                red,
  output logic                green,
  output logic                blue,
  output logic [2:0]          seg_idx,
  output logic                wrap
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int FADE_DIV = STEP_CYCLES >> PWM_BITS;
  localparam int SW = $clog2(STEP_CYCLES);
  localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic [SW-1:0]       step_cnt;
  logic [FW-1:0]       fade_cnt;
  logic [2:0]          seg;
  logic [2:0]          seg_next;
  logic [PWM_BITS-1:0] frac;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                step_tick;
  logic                fade_tick;
  logic [PWM_BITS-1:0] lvl_r, lvl_g, lvl_b;

  assign step_tick = (mode == STEP) && (step_cnt == SW'(STEP_CYCLES - 1));
  assign fade_tick = (mode == FADE) && (fade_cnt == FW'(FADE_DIV - 1));
  assign seg_next  = (seg == SEG_MAGENTA) ? SEG_RED : seg + 3'd1;

  // Each divider only advances in its own mode, so HOLD (and 11) freezes both
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt <= '0;
      fade_cnt <= '0;
      seg      <= SEG_RED;
      frac     <= '0;
      pwm_cnt  <= '0;
      wrap     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      wrap    <= 1'b0;
      if (mode == STEP) begin
        if (step_tick) begin
          step_cnt <= '0;
          frac     <= '0;
          seg      <= seg_next;
          wrap     <= (seg == SEG_MAGENTA);
        end else begin
          step_cnt <= step_cnt + SW'(1);
        end
      end else if (mode == FADE) begin
        if (fade_tick) begin
          fade_cnt <= '0;
          frac     <= frac + PWM_BITS'(1);
          if (frac == MAX) begin
            seg  <= seg_next;
            wrap <= (seg == SEG_MAGENTA);
          end
        end else begin
          fade_cnt <= fade_cnt + FW'(1);
        end
      end
    end
  end

  always_comb begin
    lvl_r = '0;
    lvl_g = '0;
    lvl_b = '0;
    case (seg)
      SEG_RED:     begin lvl_r = MAX;        lvl_g = frac;                      end
      SEG_YELLOW:  begin lvl_r = MAX - frac; lvl_g = MAX;                       end
      SEG_GREEN:   begin lvl_g = MAX;        lvl_b = frac;                      end
      SEG_CYAN:    begin lvl_g = MAX - frac; lvl_b = MAX;                       end
      SEG_BLUE:    begin lvl_r = frac;       lvl_b = MAX;                       end
      SEG_MAGENTA: begin lvl_r = MAX;        lvl_b = MAX - frac;                end
      default:     begin lvl_r = '0;         lvl_g = '0;         lvl_b = '0;    end
    endcase
  end

  assign seg_idx = seg;

  led_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch_r (
    .clk(clk), .rst_n(rst_n), .level(lvl_r), .brightness(brightness),
    .pwm_cnt(pwm_cnt), .out(red)
  );

  led_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch_g (
    .clk(clk), .rst_n(rst_n), .level(lvl_g), .brightness(brightness),
    .pwm_cnt(pwm_cnt), .out(green)
  );

  led_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch_b (
    .clk(clk), .rst_n(rst_n), .level(lvl_b), .brightness(brightness),
    .pwm_cnt(pwm_cnt), .out(blue)
  );

endmodule

// File: tb/tb_led_color_seq.sv
// Scoreboard bench for led_color_seq: a hue-position reference model queues
// the expected pins every clock and a negedge monitor compares them.
module tb_led_color_seq;

  localparam int STEP_CYCLES = 16;
  localparam int PWM_BITS    = 2;
  localparam int MAXV        = (1 << PWM_BITS) - 1;
  localparam int LEVELS      = MAXV + 1;
  localparam int FADE_DIV    = STEP_CYCLES >> PWM_BITS;
  localparam int POS_SPAN    = 6 * LEVELS;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          mode = 2'b01;
  logic [PWM_BITS-1:0] brightness = 2'd3;
  logic                red, green, blue, wrap;
  logic [2:0]          seg_idx;

  led_color_seq #(.STEP_CYCLES(STEP_CYCLES), .PWM_BITS(PWM_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .brightness(brightness),
    .red(red), .green(green), .blue(blue), .seg_idx(seg_idx), .wrap(wrap)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: {seg_idx, wrap, red, green, blue}
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int wrap_seen = 0;

  // reference model: hue position as one integer 0..POS_SPAN-1
  int pos = 0;
  int step_t = 0;
  int fade_t = 0;
  int pwm = 0;

  function automatic int level(input int p, input int ch);
    int s = p / LEVELS;
    int f = p % LEVELS;
    int up = f;
    int dn = MAXV - f;
    int l;
    case (s)
      0: l = (ch == 0) ? MAXV : (ch == 1) ? up   : 0;
      1: l = (ch == 0) ? dn   : (ch == 1) ? MAXV : 0;
      2: l = (ch == 0) ? 0    : (ch == 1) ? MAXV : up;
      3: l = (ch == 0) ? 0    : (ch == 1) ? dn   : MAXV;
      4: l = (ch == 0) ? up   : (ch == 1) ? 0    : MAXV;
      default: l = (ch == 0) ? MAXV : (ch == 1) ? 0 : dn;
    endcase
`ifdef LED_COLOR_SEQ_GAMMA_EN
    l = (l * l) >> PWM_BITS;
`endif
    return l;
  endfunction

  function automatic int duty(input int lvl, input int b);
    return (lvl * (b + 1)) >> PWM_BITS;
  endfunction

  always @(posedge clk) begin : ref_model
    logic [2:0] rgb;
    logic       w;
    rgb = 3'b000;
    w   = 1'b0;
    if (!rst_n) begin
      pos = 0; step_t = 0; fade_t = 0; pwm = 0;
    end else begin
      for (int ch = 0; ch < 3; ch++)
        rgb[2-ch] = (duty(level(pos, ch), int'(brightness)) > pwm);
      pwm = (pwm + 1) % LEVELS;
      if (mode == 2'b01) begin
        step_t++;
        if (step_t % STEP_CYCLES == 0) begin
          w   = ((pos / LEVELS) == 5);
          pos = ((pos / LEVELS + 1) % 6) * LEVELS;
        end
      end else if (mode == 2'b10) begin
        fade_t++;
        if (fade_t % FADE_DIV == 0) begin
          w   = (pos == POS_SPAN - 1);
          pos = (pos + 1) % POS_SPAN;
        end
      end
    end
    exp_q.push_back({3'(pos / LEVELS), w, rgb});
  end

  // monitor
  always @(negedge clk) begin : monitor
    logic [5:0] e;
    logic [5:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {seg_idx, wrap, red, green, blue};
      if (wrap === 1'b1) wrap_seen++;
      checks++;
      if (a !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL pins t=%0t got seg=%0d wrap=%b rgb=%b expected seg=%0d wrap=%b rgb=%b",
                   $time, a[5:3], a[2], a[1:0] == 2'b00 ? {a[2:0]} : a[2:0], e[5:3], e[2], e[2:0]);
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input int n);
    rst_n = 1'b0;
    cyc(n);
    rst_n = 1'b1;
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    // reset held 3 cycles with STEP selected: everything must read 0
    cyc(3);
    check_val("reset_pins", int'({seg_idx, wrap, red, green, blue}), 0);
    rst_n = 1'b1;

    // a full STEP revolution plus one: exactly one wrap pulse
    wrap_seen = 0;
    cyc(7 * STEP_CYCLES + 4);
    check_val("step_wrap_count", wrap_seen, 1);

    // FADE from segment 0 through a complete wheel
    pulse_reset(1);
    mode = 2'b10;
    wrap_seen = 0;
    cyc(POS_SPAN * FADE_DIV + 8);
    check_val("fade_wrap_count", wrap_seen, 1);

    // HOLD mid-fade, then resume; 11 also holds
    cyc(9);
    mode = 2'b00;
    cyc(50);
    mode = 2'b10;
    cyc(20);
    mode = 2'b11;
    cyc(12);

    // zero brightness keeps every channel dark
    brightness = 2'd0;
    mode = 2'b10;
    cyc(64);
    brightness = 2'd3;

    // reset in the middle of a fade around segment 3
    pulse_reset(1);
    mode = 2'b10;
    cyc(3 * STEP_CYCLES + 7);
    pulse_reset(1);
    check_val("reset_mid_fade_seg", int'(seg_idx), 0);
    cyc(2 * STEP_CYCLES);

    // randomized mode / brightness / reset mix
    for (int i = 0; i < 60; i++) begin
      mode = 2'($urandom_range(0, 3));
      brightness = PWM_BITS'($urandom_range(0, MAXV));
      if ($urandom_range(0, 9) == 0) pulse_reset($urandom_range(1, 2));
      cyc($urandom_range(1, 40));
    end

    cyc(2);
    @(negedge clk);
    #1;
    check_val("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_color_seq.md
LED_COLOR_SEQ -- requirements
Module: led_color_seq

Interface
REQ-001 Parameter STEP_CYCLES, default 6000000: clk cycles per colour step (0.5 s at 12 MHz); SHALL be >= 2**PWM_BITS.
REQ-002 Parameter PWM_BITS, default 8: PWM and colour-level resolution; MAX = 2**PWM_BITS-1.
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 mode  input  2  00 HOLD, 01 STEP, 10 FADE, 11 treated as HOLD.
REQ-006 brightness  input  PWM_BITS  global intensity; MAX = full.
REQ-007 red, green, blue  output  1 each  registered PWM LED drives, active-high.
REQ-008 seg_idx  output  3  current hue segment, 0..5 (RED, YELLOW, GREEN, CYAN, BLUE, MAGENTA).
REQ-009 wrap  output  1  one-cycle pulse when seg_idx goes 5 -> 0.

Function
REQ-010 Hue position SHALL be {seg (0..5), frac (PWM_BITS bits)}; levels per segment: 0 R=MAX G=frac B=0; 1 R=MAX-frac G=MAX B=0; 2 R=0 G=MAX B=frac; 3 R=0 G=MAX-frac B=MAX; 4 R=frac G=0 B=MAX; 5 R=MAX G=0 B=MAX-frac.
REQ-011 STEP: prescaler counts 0..STEP_CYCLES-1; at terminal count seg SHALL advance by 1 (5 wraps to 0) and frac SHALL be cleared.
REQ-012 FADE: sub-step divider counts 0..(STEP_CYCLES>>PWM_BITS)-1; at terminal count frac SHALL increment; frac carry from MAX SHALL advance seg (5 -> 0).
REQ-013 HOLD/11: seg, frac and both dividers SHALL freeze; PWM output SHALL continue.
REQ-014 Mode change SHALL take effect the next cycle; seg/frac SHALL carry over unchanged (STEP->FADE resumes fade mid-segment; FADE->STEP clears frac only at the next step).
REQ-015 Duty per channel SHALL be (level * (brightness+1)) >> PWM_BITS, width PWM_BITS, no overflow.
REQ-016 A free-running PWM counter 0..MAX SHALL run in all modes; channel output SHALL be registered (duty > pwm_cnt); duty 0 -> constant 0.
REQ-017 Output latency: new duty SHALL appear on pins within 2 cycles of a seg/frac change.
REQ-018 wrap SHALL assert for exactly the cycle after seg changes 5 -> 0, in STEP or FADE.
REQ-019 seg_idx SHALL equal registered seg.

Reset
REQ-020 rst_n low at a clk edge SHALL set seg=0, frac=0, all dividers and PWM counter=0, red=green=blue=0, wrap=0, regardless of mode.
REQ-021 Reset mid-step or mid-fade SHALL discard partial counts; first step after release SHALL occur STEP_CYCLES cycles later.

Configuration
REQ-022 Macro LED_COLOR_SEQ_GAMMA_EN defined: level SHALL be replaced by (level*level) >> PWM_BITS before brightness scaling (MAX maps to MAX-1 for PWM_BITS>=1, 0 maps to 0).
REQ-023 Macro undefined: linear levels per REQ-010; no gamma logic SHALL be synthesised.

Structure
REQ-024 Package led_color_seq_pkg SHALL hold mode enum (HOLD, STEP, FADE), segment constants SEG_RED..SEG_MAGENTA, NUM_SEGS=6.
REQ-025 Sub-module led_pwm_ch (level, brightness, pwm_cnt -> registered out, holds gamma/scale) SHALL be instanced once per channel.

Verification (STEP_CYCLES=16, PWM_BITS=2, MAX=3)
REQ-026 Reset held 3 cycles, mode=STEP -> outputs 0 during reset; seg_idx 0,1,2,3,4,5,0 at 16-cycle spacing; wrap one pulse at 5->0.
REQ-027 mode=STEP, brightness=3, seg=0 -> red duty 3/4, green 0, blue 0 over each 4-cycle PWM period; seg=1 -> red and green both 3/4.
REQ-028 mode=FADE from seg 0 -> green duty 0,1,2,3 (of 4) stepping every 4 cycles, then seg_idx=1 with red falling 3,2,1,0.
REQ-029 brightness=0 any mode -> duty (level*1)>>2 = 0 for levels <4: all outputs stay 0.
REQ-030 mode=HOLD mid-fade for 50 cycles -> seg_idx/frac unchanged, PWM pattern unchanged; back to FADE resumes same frac.
REQ-031 rst_n low mid-FADE at seg 3 -> next cycle seg_idx=0, outputs 0; with LED_COLOR_SEQ_GAMMA_EN, seg 0 frac 2 -> green duty 1/4.
